// File: rtl/lbm_moment_accum.sv
// D2Q9 moment accumulator: serially sums nine f_i into density (rho) and x-momentum (jx).
// Define LBM_MOMENT_SAT_EN for saturating arithmetic with a sticky overflow flag.
module lbm_moment_accum #(
    parameter int DW = 64,
    parameter int NQ = 9
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [DW*NQ-1:0] Cx_In,
    input  logic [DW-1:0]    F_In,
    input  logic             F_Valid,
    output logic             F_Ready,
    output logic [DW-1:0]    Rho_Out,
    output logic [DW-1:0]    Jx_Out,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic             Ovf_Out
);
    localparam int IW = $clog2(NQ);
    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic {ACC, OUT} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   rho, jx;
    logic            ovf;
    logic            beat, last;
    logic [DW-1:0]   lane;
    logic [DW:0]     rho_step, jx_step;
    logic            cx_zero, cx_neg;

    // Returns {overflow, result}; overflow only reported when saturation is enabled.
    function automatic logic [DW:0] addsub(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic sub);
        logic [DW-1:0] s;
        logic          o;
        s = sub ? a - b : a + b;
        o = (sub ? (a[DW-1] != b[DW-1]) : (a[DW-1] == b[DW-1])) && (s[DW-1] != a[DW-1]);
`ifdef LBM_MOMENT_SAT_EN
        if (o) s = a[DW-1] ? SMIN : SMAX;
`else
        o = 1'b0;
`endif
        return {o, s};
    endfunction

    always_comb begin
        lane = '0;
        for (int k = 0; k < NQ; k++)
            if (idx == IW'(k)) lane = Cx_In[DW*(NQ-k)-1 -: DW];
    end

    assign cx_zero = (lane == '0);
    assign cx_neg  = lane[DW-1];
    assign beat    = F_Valid && F_Ready;
    assign last    = (idx == IW'(NQ-1));

    // First beat of a node starts from zero so stale sums never leak forward.
    always_comb begin
        rho_step = addsub((idx == '0) ? '0 : rho, F_In, 1'b0);
        jx_step  = addsub((idx == '0) ? '0 : jx, F_In, cx_neg);
        if (cx_zero) jx_step = {1'b0, (idx == '0) ? '0 : jx};
    end

    always_ff @(posedge Clk) begin
        if (!Reset) state <= ACC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        F_Ready   = 1'b0;
        Out_Valid = 1'b0;
        case (state)
            ACC: begin
                F_Ready = 1'b1;
                if (beat && last) state_nxt = OUT;
            end
            OUT: begin
                Out_Valid = 1'b1;
                if (Out_Ready) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            idx <= '0;
            rho <= '0;
            jx  <= '0;
            ovf <= 1'b0;
        end else if (beat) begin
            idx <= last ? '0 : idx + 1'b1;
            rho <= rho_step[DW-1:0];
            jx  <= jx_step[DW-1:0];
            ovf <= ((idx == '0) ? 1'b0 : ovf) | rho_step[DW] | jx_step[DW];
        end
    end

    assign Rho_Out = rho;
    assign Jx_Out  = jx;
    assign Ovf_Out = ovf;
endmodule

// File: tb/tb_lbm_moment_accum.sv
// Directed bench for lbm_moment_accum; expectations are hand-computed per node.
module tb_lbm_moment_accum;
    localparam int DW = 64;
    localparam int NQ = 9;
    localparam logic [DW-1:0] ONE  = 64'h0100_0000_0000_0000;
    localparam logic [DW-1:0] MONE = 64'hFF00_0000_0000_0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DW*NQ-1:0] cx;
    logic [DW-1:0]    f_in;
    logic             f_valid, f_ready;
    logic [DW-1:0]    rho, jx;
    logic             out_valid, out_ready, ovf;

    int passed = 0;
    int total  = 0;

    lbm_moment_accum #(.DW(DW), .NQ(NQ)) dut (
        .Clk(clk), .Reset(rst_n), .Cx_In(cx), .F_In(f_in), .F_Valid(f_valid),
        .F_Ready(f_ready), .Rho_Out(rho), .Jx_Out(jx), .Out_Valid(out_valid),
        .Out_Ready(out_ready), .Ovf_Out(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // f_k = base for all k, or f_k = k*1.0 when ramp is set; gap inserts an idle cycle after each beat.
    task automatic send_node(input logic [DW-1:0] base, input bit ramp, input bit gap);
        for (int k = 0; k < NQ; k++) begin
            f_in    = ramp ? DW'(k) << 56 : base;
            f_valid = 1'b1;
            tick();
            if (gap) begin
                f_valid = 1'b0;
                f_in    = 64'hDEAD_BEEF_0000_0000;
                if (k < NQ-1) check("gap_no_early_valid", 64'(out_valid), 64'd0);
                if (k < NQ-1) tick();
            end
        end
        f_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("consume_valid_low", 64'(out_valid), 64'd0);
        check("consume_ready_high", 64'(f_ready), 64'd1);
    endtask

    initial begin
        logic [DW-1:0] cxv [NQ];
        cxv = '{64'd0, ONE, 64'd0, MONE, 64'd0, ONE, MONE, MONE, ONE};
        for (int k = 0; k < NQ; k++) cx[DW*(NQ-k)-1 -: DW] = cxv[k];
        rst_n = 1'b0; f_in = '0; f_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        check("rst_rho", rho, '0);
        check("rst_jx", jx, '0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rst_f_ready", 64'(f_ready), 64'd1);

        // Test 1: all ones
        send_node(ONE, 1'b0, 1'b0);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_rho", rho, 64'h0900_0000_0000_0000);
        check("t1_jx", jx, '0);
        check("t1_ovf", 64'(ovf), 64'd0);
        check("t1_f_ready", 64'(f_ready), 64'd0);
        consume();

        // Test 2 and 3: ramp, then backpressure for 5 cycles
        send_node('0, 1'b1, 1'b0);
        check("t2_valid", 64'(out_valid), 64'd1);
        check("t2_rho", rho, 64'h2400_0000_0000_0000);
        check("t2_jx", jx, 64'hFE00_0000_0000_0000);
        f_valid = 1'b1; f_in = ONE;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t3_hold_valid", 64'(out_valid), 64'd1);
            check("t3_hold_f_ready", 64'(f_ready), 64'd0);
            check("t3_hold_rho", rho, 64'h2400_0000_0000_0000);
            check("t3_hold_jx", jx, 64'hFE00_0000_0000_0000);
        end
        f_valid = 1'b0;
        consume();
        send_node(ONE, 1'b0, 1'b0);
        check("t3_fresh_rho", rho, 64'h0900_0000_0000_0000);
        check("t3_fresh_jx", jx, '0);
        consume();

        // Test 4: F_Valid toggling
        send_node('0, 1'b1, 1'b1);
        check("t4_valid", 64'(out_valid), 64'd1);
        check("t4_rho", rho, 64'h2400_0000_0000_0000);
        check("t4_jx", jx, 64'hFE00_0000_0000_0000);
        consume();

        // Test 5: reset after 4 beats
        f_valid = 1'b1; f_in = 64'h0500_0000_0000_0000;
        for (int k = 0; k < 4; k++) tick();
        f_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_rst_rho", rho, '0);
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        send_node(ONE, 1'b0, 1'b0);
        check("t5_valid", 64'(out_valid), 64'd1);
        check("t5_rho", rho, 64'h0900_0000_0000_0000);
        check("t5_jx", jx, '0);
        consume();

        // Test 6: large values
        send_node(64'h7F00_0000_0000_0000, 1'b0, 1'b0);
        check("t6_valid", 64'(out_valid), 64'd1);
        check("t6_jx", jx, '0);
`ifdef LBM_MOMENT_SAT_EN
        check("t6_rho", rho, 64'h7FFF_FFFF_FFFF_FFFF);
        check("t6_ovf", 64'(ovf), 64'd1);
`else
        check("t6_rho", rho, 64'h7700_0000_0000_0000);
        check("t6_ovf", 64'(ovf), 64'd0);
`endif
        consume();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
